// File: rtl/cache_pkg.sv
// Shared FSM encoding and the one-hot word-select helper for the cache fill arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    TAGWR = 2'd3
  } fillState_e;

  // Wide enough for the largest block (16 words); callers truncate to BLK_WORDS.
  localparam int ONEHOT_W     = 16;
  localparam int ONEHOT_IDX_W = 5;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Memory-side bus of the fill arbiter: one request per cycle, fixed-latency read return.
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at the channel after the last grant.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  lastGnt_i,
  output logic              gntValid_o,
  output logic [IDX_W-1:0]  gntIdx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gntValid_o = 1'b0;
    gntIdx_o   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(lastGnt_i) + k) % NUM_CH);
      if (!gntValid_o && req_i[cand]) begin
        gntValid_o = 1'b1;
        gntIdx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory port between write-throughs and round-robin cache block fills.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic [NUM_CH-1:0]        fill_data_we,
  output logic [NUM_CH-1:0]        fill_tag_we,
  output logic [BLK_WORDS-1:0]     fill_word_sel,
  output logic [DATA_W-1:0]        fill_data,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        stall,
  cache_fill_arbiter_if.master     mem_bus
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BLK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * BLK_WORDS - 1);

  fillState_e        state_q, state_d;
  logic [CNT_W-1:0]  issueCnt_q, issueCnt_d;
  logic [CNT_W-1:0]  recvCnt_q, recvCnt_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              arbValid;
  logic [IDX_W-1:0]  arbIdx;
  logic [ADDR_W-1:0] missAddrSel;
  logic              idleGrant;
  logic              rdAccept;

  // grant_q doubles as the round-robin pointer: the next search starts after it.
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i      (miss_req),
    .lastGnt_i  (grant_q),
    .gntValid_o (arbValid),
    .gntIdx_o   (arbIdx)
  );

  assign missAddrSel = miss_addr[arbIdx*ADDR_W +: ADDR_W];
  assign idleGrant   = (state_q == IDLE) && !wr_req && arbValid;
  assign rdAccept    = ((state_q == ISSUE) || (state_q == DRAIN)) && mem_bus.mem_rvalid
                       && (recvCnt_q <= LAST_WORD);

  always_comb begin
    state_d    = state_q;
    issueCnt_d = issueCnt_q;
    recvCnt_d  = recvCnt_q;
    grant_d    = grant_q;
    base_d     = base_q;
    unique case (state_q)
      IDLE: begin
        if (idleGrant) begin
          state_d    = ISSUE;
          grant_d    = arbIdx;
          base_d     = missAddrSel & ~BLK_MASK;
          issueCnt_d = '0;
          recvCnt_d  = '0;
        end
      end
      ISSUE: begin
        issueCnt_d = issueCnt_q + 1'b1;
        if (issueCnt_q == LAST_WORD) state_d = DRAIN;
      end
      DRAIN: ;
      TAGWR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Returns can overlap the issue phase when memory latency is shorter than the block.
    if (rdAccept) begin
      recvCnt_d = recvCnt_q + 1'b1;
      if (recvCnt_q == LAST_WORD) state_d = TAGWR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      issueCnt_q <= '0;
      recvCnt_q  <= '0;
      grant_q    <= IDX_W'(NUM_CH - 1);
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      issueCnt_q <= issueCnt_d;
      recvCnt_q  <= recvCnt_d;
      grant_q    <= grant_d;
      base_q     <= base_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the request inputs.
  always_comb begin
    wr_ack            = 1'b0;
    mem_bus.mem_en    = 1'b0;
    mem_bus.mem_wr    = 1'b0;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = '0;
    fill_data_we      = '0;
    fill_tag_we       = '0;
    fill_word_sel     = '0;
    fill_data         = '0;
    busy              = '0;
    stall             = '0;
    if (rst) begin
      if ((state_q == IDLE) && wr_req) begin
        wr_ack            = 1'b1;
        mem_bus.mem_en    = 1'b1;
        mem_bus.mem_wr    = 1'b1;
        mem_bus.mem_addr  = wr_addr;
        mem_bus.mem_wdata = wr_data;
      end
      if (state_q == ISSUE) begin
        mem_bus.mem_en   = 1'b1;
        mem_bus.mem_addr = base_q + ADDR_W'({issueCnt_q, 1'b0});
      end
      if (state_q == TAGWR) fill_tag_we[grant_q] = 1'b1;
      if (rdAccept) begin
        fill_data_we[grant_q] = 1'b1;
        fill_word_sel         = BLK_WORDS'(onehot(ONEHOT_IDX_W'(recvCnt_q)));
        fill_data             = mem_bus.mem_rdata;
      end
      if (state_q != IDLE) busy[grant_q] = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        stall[i] = busy[i] | (miss_req[i] & ~(idleGrant && (arbIdx == IDX_W'(i))));
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed self-checking bench for cache_fill_arbiter with a 4-cycle pipelined memory model.
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  missReq;
  logic [15:0] missAddr0, missAddr1;
  logic [31:0] missAddrBus;
  logic        wrReq;
  logic [15:0] wrAddr, wrData;
  logic        wrAck;
  logic [1:0]  fillDataWe, fillTagWe, busy, stall;
  logic [7:0]  fillWordSel;
  logic [15:0] fillData;

  logic [3:0]  missReq4;
  logic [63:0] missAddr4;
  logic        wrAck4;
  logic [3:0]  dataWe4, tagWe4, busy4, stall4, wordSel4;
  logic [15:0] fillData4;

  int checks;
  int errors;
  int gotCh[$];
  int expOrder[5];
  int reads, cyc, curCh;
  logic [3:0] prevBusy;

  cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus4 ();

  assign missAddrBus = {missAddr1, missAddr0};

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst), .miss_req(missReq), .miss_addr(missAddrBus),
    .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_ack(wrAck),
    .fill_data_we(fillDataWe), .fill_tag_we(fillTagWe), .fill_word_sel(fillWordSel),
    .fill_data(fillData), .busy(busy), .stall(stall), .mem_bus(bus)
  );

  cache_fill_arbiter #(.NUM_CH(4), .BLK_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .miss_req(missReq4), .miss_addr(missAddr4),
    .wr_req(1'b0), .wr_addr(16'h0000), .wr_data(16'h0000), .wr_ack(wrAck4),
    .fill_data_we(dataWe4), .fill_tag_we(tagWe4), .fill_word_sel(wordSel4),
    .fill_data(fillData4), .busy(busy4), .stall(stall4), .mem_bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined memory models: a read issued in cycle t returns in cycle t+4 with data addr^0x5A5A.
  logic [3:0]  rdV, rdV4;
  logic [15:0] rdA [4];
  logic [15:0] rdA4 [4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdV  <= '0;
      rdV4 <= '0;
    end else begin
      rdV     <= {rdV[2:0], bus.mem_en & ~bus.mem_wr};
      rdV4    <= {rdV4[2:0], bus4.mem_en & ~bus4.mem_wr};
      rdA[0]  <= bus.mem_addr;
      rdA4[0] <= bus4.mem_addr;
      for (int i = 1; i < 4; i++) begin
        rdA[i]  <= rdA[i-1];
        rdA4[i] <= rdA4[i-1];
      end
    end
  end

  assign bus.mem_rvalid  = rdV[3];
  assign bus.mem_rdata   = rdA[3] ^ 16'h5A5A;
  assign bus4.mem_rvalid = rdV4[3];
  assign bus4.mem_rdata  = rdA4[3] ^ 16'h5A5A;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                               input logic wr, input logic [15:0] wa, input logic [15:0] wd);
    missReq   = req;
    missAddr0 = a0;
    missAddr1 = a1;
    wrReq     = wr;
    wrAddr    = wa;
    wrData    = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Walks cycles 1..13 after a grant cycle on the 2-channel, 8-word, latency-4 instance.
  task automatic checkFill(input int ch, input logic [15:0] base, input logic [1:0] reqDuring,
                           input logic [1:0] stallExp, input logic wrDuring);
    for (int c = 1; c <= 13; c++) begin
      nextCycle();
      if (c == 1) begin
        missReq = reqDuring;
        if (ch == 0) missAddr0 = missAddr0 ^ 16'hF0F0;
        else         missAddr1 = missAddr1 ^ 16'hF0F0;
        if (wrDuring) begin
          wrReq  = 1'b1;
          wrAddr = 16'h3000;
          wrData = 16'h1234;
        end
      end
      @(negedge clk);
      checkOutput("busy", busy, 32'(1) << ch);
      checkOutput("stall", stall, 32'(stallExp));
      checkOutput("memEn", bus.mem_en, (c <= 8) ? 32'd1 : 32'd0);
      checkOutput("memWr", bus.mem_wr, 32'd0);
      if (c <= 8) checkOutput("rdAddr", bus.mem_addr, 32'(base + 16'(2 * (c - 1))));
      checkOutput("dataWe", fillDataWe, (c >= 5 && c <= 12) ? (32'(1) << ch) : 32'd0);
      if (c >= 5 && c <= 12) begin
        checkOutput("wordSel", fillWordSel, 32'(1) << (c - 5));
        checkOutput("fillData", fillData, 32'((base + 16'(2 * (c - 5))) ^ 16'h5A5A));
      end
      checkOutput("tagWe", fillTagWe, (c == 13) ? (32'(1) << ch) : 32'd0);
      if (wrDuring) checkOutput("wrAckHeld", wrAck, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    expOrder = '{0, 1, 2, 3, 0};
    rst      = 1'b0;
    missReq4  = 4'h0;
    missAddr4 = {16'h3015, 16'h2015, 16'h1015, 16'h0015};
    applyStimulus(2'b11, 16'h1234, 16'h0100, 1'b1, 16'h2000, 16'hBEEF);

    // Reset holds every output low even with requests pending.
    @(negedge clk);
    checkOutput("rstMemEn", bus.mem_en, 32'd0);
    checkOutput("rstWrAck", wrAck, 32'd0);
    checkOutput("rstStall", stall, 32'd0);
    checkOutput("rstBusy", busy, 32'd0);

    // Single I-miss at 0x1234.
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b01, 16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("g0Stall", stall, 32'd0);
    checkOutput("g0Busy", busy, 32'd0);
    checkOutput("g0MemEn", bus.mem_en, 32'd0);
    checkFill(0, 16'h1230, 2'b00, 2'b01, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1IdleBusy", busy, 32'd0);
    checkOutput("t1IdleTag", fillTagWe, 32'd0);

    // I- and D-miss together right after reset: channel 0 first.
    nextCycle();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b11, 16'h0040, 16'h0100, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("bothStall", stall, 32'h2);
    checkFill(0, 16'h0040, 2'b11, 2'b11, 1'b0);
    nextCycle();
    missReq = 2'b10;
    @(negedge clk);
    checkOutput("ch1GrantStall", stall, 32'd0);
    checkOutput("ch1GrantMemEn", bus.mem_en, 32'd0);
    checkFill(1, 16'h0100, 2'b00, 2'b10, 1'b0);

    // Write-through beats a simultaneous D-miss, miss granted the next cycle.
    nextCycle();
    applyStimulus(2'b10, 16'h0000, 16'h0300, 1'b1, 16'h2000, 16'hBEEF);
    @(negedge clk);
    checkOutput("wrAck", wrAck, 32'd1);
    checkOutput("wrMemEn", bus.mem_en, 32'd1);
    checkOutput("wrMemWr", bus.mem_wr, 32'd1);
    checkOutput("wrAddr", bus.mem_addr, 32'h2000);
    checkOutput("wrData", bus.mem_wdata, 32'hBEEF);
    checkOutput("wrStall", stall, 32'h2);
    nextCycle();
    wrReq = 1'b0;
    @(negedge clk);
    checkOutput("postWrAck", wrAck, 32'd0);
    checkOutput("postWrStall", stall, 32'd0);
    checkFill(1, 16'h0300, 2'b00, 2'b10, 1'b0);

    // Write arriving mid-fill waits for IDLE, then issues exactly once.
    nextCycle();
    applyStimulus(2'b01, 16'h0500, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("t4Stall", stall, 32'd0);
    checkFill(0, 16'h0500, 2'b00, 2'b01, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("heldWrAck", wrAck, 32'd1);
    checkOutput("heldWrMemWr", bus.mem_wr, 32'd1);
    checkOutput("heldWrAddr", bus.mem_addr, 32'h3000);
    checkOutput("heldWrData", bus.mem_wdata, 32'h1234);
    nextCycle();
    wrReq = 1'b0;
    @(negedge clk);
    checkOutput("singleWrAck", wrAck, 32'd0);
    checkOutput("singleWrMemEn", bus.mem_en, 32'd0);

    // Reset at the 4th returned word abandons the fill.
    nextCycle();
    applyStimulus(2'b01, 16'h0700, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      if (c == 1) missReq = 2'b00;
      @(negedge clk);
      if (c == 7) checkOutput("preRstDataWe", fillDataWe, 32'd1);
    end
    nextCycle();
    rst = 1'b0;
    applyStimulus(2'b11, 16'h0000, 16'h0000, 1'b1, 16'h4000, 16'h5555);
    @(negedge clk);
    checkOutput("midRstDataWe", fillDataWe, 32'd0);
    checkOutput("midRstWordSel", fillWordSel, 32'd0);
    checkOutput("midRstMemEn", bus.mem_en, 32'd0);
    checkOutput("midRstBusy", busy, 32'd0);
    checkOutput("midRstStall", stall, 32'd0);
    checkOutput("midRstWrAck", wrAck, 32'd0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("noTagAfterRst", fillTagWe, 32'd0);
      checkOutput("idleAfterRst", busy, 32'd0);
      nextCycle();
    end
    applyStimulus(2'b11, 16'h0B00, 16'h0D00, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("rstPtrStall", stall, 32'h2);
    checkFill(0, 16'h0B00, 2'b10, 2'b11, 1'b0);
    nextCycle();
    missReq = 2'b00;

    // Four channels requesting continuously on the 4-word instance.
    reads    = 0;
    cyc      = 0;
    curCh    = 0;
    prevBusy = '0;
    missReq4 = 4'hF;
    while (gotCh.size() < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy4 != 4'h0 && prevBusy == 4'h0) begin
        for (int i = 0; i < 4; i++) if (busy4[i]) curCh = i;
        gotCh.push_back(curCh);
      end
      if (bus4.mem_en) begin
        if (reads == 0) checkOutput("rd4Base", bus4.mem_addr, 32'(curCh * 32'h1000 + 32'h10));
        reads++;
      end
      if (tagWe4 != 4'h0) begin
        checkOutput("rd4Count", reads, 32'd4);
        checkOutput("tag4Ch", tagWe4, 32'(1) << curCh);
        reads = 0;
      end
      prevBusy = busy4;
      nextCycle();
    end
    missReq4 = 4'h0;
    checkOutput("grant4Count", gotCh.size(), 32'd5);
    for (int k = 0; k < gotCh.size() && k < 5; k++) checkOutput("grant4Order", gotCh[k], expOrder[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of cache channels requesting fills (channel 0 = I-cache, 1 = D-cache).
REQ-002 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-003 SHALL have parameter DATA_W, default 16: word width.
REQ-004 SHALL have parameter BLK_WORDS, default 8: words per block, power of two, 2..16; OFF_W = log2(BLK_WORDS).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port miss_req, input, NUM_CH: per-channel fill request.
REQ-008 SHALL have port miss_addr, input, NUM_CH*ADDR_W: per-channel miss byte address.
REQ-009 SHALL have port wr_req, input, 1: D-cache write-through request.
REQ-010 SHALL have port wr_addr / wr_data, input, ADDR_W / DATA_W: write-through address and data.
REQ-011 SHALL have port wr_ack, output, 1: one-cycle pulse when the write is issued to memory.
REQ-012 SHALL have port fill_data_we, output, NUM_CH: data-array write strobe per channel.
REQ-013 SHALL have port fill_tag_we, output, NUM_CH: tag-array write strobe per channel.
REQ-014 SHALL have port fill_word_sel, output, BLK_WORDS: one-hot word select for the returning word.
REQ-015 SHALL have port fill_data, output, DATA_W: returning memory word.
REQ-016 SHALL have port busy / stall, output, NUM_CH each: fill owned / requester must hold.
REQ-017 SHALL have ports mem_en, mem_wr (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W) and mem_rvalid (input, 1) to the pipelined fixed-latency memory; that memory accepts one request per cycle.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> TAGWR -> IDLE.
REQ-019 IDLE: a pending wr_req SHALL win over misses. In that cycle: mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1. The FSM stays in IDLE.
REQ-020 IDLE with no wr_req and any miss_req: SHALL grant round-robin, starting after the last granted channel (initially channel 0). It latches the block base {miss_addr[ADDR_W-1:OFF_W+1], 0} and goes to ISSUE.
REQ-021 ISSUE: SHALL issue BLK_WORDS back-to-back reads (mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt), one per cycle, then go to DRAIN.
REQ-022 ISSUE/DRAIN: on each mem_rvalid the block SHALL, in the same cycle:
  - assert fill_data_we[grant]
  - set fill_word_sel = onehot(recv_cnt)
  - set fill_data = mem_rdata
  - increment recv_cnt
REQ-023 When recv_cnt reaches BLK_WORDS, the FSM SHALL enter TAGWR. TAGWR asserts fill_tag_we[grant] for exactly one cycle, then returns to IDLE.
REQ-024 busy[grant] SHALL be high from the cycle after grant through TAGWR inclusive. All other busy bits stay 0.
REQ-025 stall[i] SHALL equal busy[i] | (miss_req[i] & ~(state==IDLE & granted_this_cycle==i)).
REQ-026 Deassertion of miss_req or changes to miss_addr during a fill SHALL be ignored; the fill always completes.
REQ-027 wr_req arriving while not in IDLE SHALL be held off (wr_ack=0) until IDLE.
REQ-028 mem_rvalid in IDLE or TAGWR SHALL be ignored.
REQ-029 Counters SHALL be OFF_W+1 bits wide with no wrap-around. Addresses wrap modulo 2^ADDR_W only inside the block.
REQ-030 Fill latency SHALL be 1 (grant) + BLK_WORDS + memory latency + 1 (TAGWR) cycles.
REQ-031 Simultaneous requests in IDLE: wr_req is served first. In the next IDLE cycle the round-robin winner among miss_req is granted.

Reset
REQ-032 On rst low, state SHALL go to IDLE immediately, with counters=0, round-robin pointer=NUM_CH-1 (so channel 0 wins first) and all outputs 0.
REQ-033 Reset mid-fill SHALL abandon the fill with no tag write. Memory shares rst, so no stale returns are expected.

Structure
REQ-034 FSM state encoding and the onehot helper width SHALL live in shared package cache_pkg.
REQ-035 The round-robin arbiter SHALL be the single sub-module rr_arbiter (NUM_CH parameter).

Verification
REQ-036 Single I-miss, addr 0x1234, memory latency 4 -> reads 0x1230..0x123E; fill_data_we[0] x8 with word_sel 0x01..0x80; fill_tag_we[0] one cycle; total 14 cycles.
REQ-037 I- and D-miss in the same cycle after reset -> channel 0 filled first, then channel 1; stall[1]=1 throughout the channel 0 fill.
REQ-038 wr_req (0x2000, 0xBEEF) together with miss_req[1] -> wr_ack with mem_wr=1 in the first cycle; grant to channel 1 the next cycle.
REQ-039 wr_req during a fill -> wr_ack=0 until IDLE, then exactly one write.
REQ-040 rst low at the 4th returned word -> all outputs 0 within the cycle; no fill_tag_we; the next miss fills cleanly.
REQ-041 NUM_CH=4, BLK_WORDS=4, all channels requesting continuously -> grants in order 0,1,2,3,0; each fill issues 4 reads.
